// File: rtl/display_sel_pkg.sv
// display_sel_pkg: shared state type and width helpers for the display source selector
package display_sel_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    // max(1, clog2(n)): select width for n sources
    function automatic int sel_width(input int n);
        return n > 2 ? $clog2(n) : 1;
    endfunction

    // clog2(max(a, b, 2)): counter width able to hold both terminal counts
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m > 2 ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/display_sel_timer.sv
// display_sel_timer: enabled cycle counter with clear and a terminal-count pulse every COUNT enabled cycles
module display_sel_timer #(
    parameter int COUNT = 2,
    parameter int W     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    logic [W-1:0] cnt;

    assign tc = en && !load && cnt == LAST;

    // count enabled cycles, wrapping to zero on the terminal count
    always_ff @(posedge clk) begin
        if (reset || load) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/display_source_selector.sv
// display_source_selector: registered N-way 7-segment source selector with auto-rotation and blanking; optional blink via DISPLAY_SEL_BLINK_EN
module display_source_selector
    import display_sel_pkg::*;
#(
    parameter int               SEG_W        = 7,
    parameter int               N_SRC        = 2,
    parameter int               DWELL_CYCLES = 50_000_000,
    parameter int               BLANK_CYCLES = 1_000_000,
    parameter logic [SEG_W-1:0] BLANK_VALUE  = {SEG_W{1'b0}},
`ifdef DISPLAY_SEL_BLINK_EN
    parameter int               BLINK_CYCLES = 25_000_000,
`endif
    parameter int               SEL_W        = sel_width(N_SRC)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC*SEG_W-1:0] src_bus,
    input  logic [SEL_W-1:0]       manual_sel,
    input  logic                   auto_en,
`ifdef DISPLAY_SEL_BLINK_EN
    input  logic                   blink,
`endif
    output logic [SEG_W-1:0]       seg_out,
    output logic [SEL_W-1:0]       active_src,
    output logic                   switching
);

    localparam int               CNT_W    = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
    localparam int               BLANK_N  = BLANK_CYCLES > 0 ? BLANK_CYCLES : 1;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_SRC - 1);

    state_t           state, state_n;
    logic [SEL_W-1:0] cur_idx, cur_n, tgt_idx, tgt_n, auto_idx;
    logic [SEG_W-1:0] seg_n;
    logic             manual_ok, dwell_tc, blank_tc, blank_phase;

    assign manual_ok  = 32'(manual_sel) < N_SRC;
    assign auto_idx   = cur_idx == LAST_IDX ? '0 : cur_idx + 1'b1;
    assign active_src = state == BLANK ? tgt_idx : cur_idx;
    assign switching  = state == BLANK;

    display_sel_timer #(.COUNT(DWELL_CYCLES), .W(CNT_W)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .load  (!auto_en),
        .en    (auto_en && state == SHOW),
        .tc    (dwell_tc)
    );

    display_sel_timer #(.COUNT(BLANK_N), .W(CNT_W)) u_blank (
        .clk   (clk),
        .reset (reset),
        .load  (state == SHOW),
        .en    (state == BLANK),
        .tc    (blank_tc)
    );

`ifdef DISPLAY_SEL_BLINK_EN
    logic phase, blink_tc;

    display_sel_timer #(.COUNT(BLINK_CYCLES), .W(cnt_width(BLINK_CYCLES, 2))) u_blink (
        .clk   (clk),
        .reset (reset),
        .load  (!blink || state != SHOW),
        .en    (blink && state == SHOW),
        .tc    (blink_tc)
    );

    // blink phase toggles every BLINK_CYCLES shown cycles and restarts dark-free on each new show
    always_ff @(posedge clk) begin
        if (reset || !blink || state != SHOW) phase <= 1'b0;
        else if (blink_tc) phase <= ~phase;
    end

    assign blank_phase = blink && state == SHOW && (blink_tc ? ~phase : phase);
`else
    assign blank_phase = 1'b0;
`endif

    // next state, target selection and the segment pattern for the next cycle
    always_comb begin
        state_n = state;
        cur_n   = cur_idx;
        tgt_n   = tgt_idx;
        if (state == SHOW) begin
            if (auto_en ? dwell_tc : manual_ok && manual_sel != cur_idx) begin
                tgt_n = auto_en ? auto_idx : manual_sel;
                if (BLANK_CYCLES == 0) cur_n = tgt_n;
                else state_n = BLANK;
            end
        end else begin
            if (!auto_en && manual_ok) tgt_n = manual_sel;
            if (blank_tc) begin
                cur_n   = tgt_n;
                state_n = SHOW;
            end
        end
        seg_n = state_n == BLANK || blank_phase ? BLANK_VALUE : src_bus[cur_n*SEG_W +: SEG_W];
    end

    // state, indices and the registered display lines
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SHOW;
            cur_idx <= '0;
            tgt_idx <= '0;
            seg_out <= BLANK_VALUE;
        end else begin
            state   <= state_n;
            cur_idx <= cur_n;
            tgt_idx <= tgt_n;
            seg_out <= seg_n;
        end
    end

endmodule

// File: tb/tb_display_source_selector.sv
// tb_display_source_selector: model-checked bench for a blanking (N=2) and a no-blank (N=3) selector
module tb_display_source_selector;

    typedef struct {
        int         shown;
        int         pending;
        int         left;
        int         dwell;
        bit         blanking;
        logic [6:0] seg;
    } mdl_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [13:0] src_a  = {7'h06, 7'h3F};
    logic [20:0] src_b  = {7'h5B, 7'h06, 7'h3F};
    logic        man_a  = 1'b0;
    logic        auto_a = 1'b0;
    logic [1:0]  man_b  = 2'd0;
    logic        auto_b = 1'b0;
    logic [6:0]  seg_a, seg_b;
    logic        act_a, sw_a, sw_b;
    logic [1:0]  act_b;
    int          vectors     = 0;
    int          miscompares = 0;
    bit          started     = 1'b0;
    mdl_t        ma, mb;

    always #5 clk = ~clk;

    display_source_selector #(
        .SEG_W(7), .N_SRC(2), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .BLANK_VALUE(7'h00)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .src_bus    (src_a),
        .manual_sel (man_a),
        .auto_en    (auto_a),
`ifdef DISPLAY_SEL_BLINK_EN
        .blink      (1'b0),
`endif
        .seg_out    (seg_a),
        .active_src (act_a),
        .switching  (sw_a)
    );

    display_source_selector #(
        .SEG_W(7), .N_SRC(3), .DWELL_CYCLES(4), .BLANK_CYCLES(0), .BLANK_VALUE(7'h00)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .src_bus    (src_b),
        .manual_sel (man_b),
        .auto_en    (auto_b),
`ifdef DISPLAY_SEL_BLINK_EN
        .blink      (1'b0),
`endif
        .seg_out    (seg_b),
        .active_src (act_b),
        .switching  (sw_b)
    );

    // one clock edge of the selector's rules: rotation by dwell, blank countdown, retargeting
    function automatic mdl_t step(mdl_t m, bit rst, bit au, int msel, int n, int dw, int bl, logic [20:0] src);
        int req;
        req = -1;
        if (rst) begin
            m.shown = 0; m.pending = 0; m.left = 0; m.dwell = 0; m.blanking = 0; m.seg = 7'h00;
            return m;
        end
        if (m.blanking) begin
            if (!au && msel < n) m.pending = msel;
            m.left--;
            if (m.left == 0) begin
                m.shown = m.pending;
                m.blanking = 0;
            end
        end else if (au) begin
            m.dwell++;
            if (m.dwell == dw) begin
                m.dwell = 0;
                req = (m.shown + 1) % n;
            end
        end else if (msel < n && msel != m.shown) begin
            req = msel;
        end
        if (!au) m.dwell = 0;
        if (req >= 0) begin
            if (bl == 0) m.shown = req;
            else begin
                m.pending = req;
                m.blanking = 1;
                m.left = bl;
            end
        end
        m.seg = m.blanking ? 7'h00 : src[m.shown*7 +: 7];
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        ma = step(ma, reset, auto_a, int'(man_a), 2, 4, 2, {7'h00, src_a});
        mb = step(mb, reset, auto_b, int'(man_b), 3, 4, 0, src_b);
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc a seg", 32'(seg_a), 32'(ma.seg));
            chk("cyc a sw", 32'(sw_a), 32'(ma.blanking));
            chk("cyc a act", 32'(act_a), ma.blanking ? ma.pending : ma.shown);
            chk("cyc b seg", 32'(seg_b), 32'(mb.seg));
            chk("cyc b sw", 32'(sw_b), 32'(mb.blanking));
            chk("cyc b act", 32'(act_b), mb.blanking ? mb.pending : mb.shown);
        end
    end

    initial begin
        tick(2);
        chk("reset seg", 32'(seg_a), 32'h00);
        chk("reset sw", 32'(sw_a), 32'h0);
        chk("reset act", 32'(act_a), 32'h0);
        reset = 1'b0;
        tick(1);
        chk("first seg", 32'(seg_a), 32'h3F);
        src_a[6:0] = 7'h66;
        tick(1);
        chk("src latency", 32'(seg_a), 32'h66);
        src_a[6:0] = 7'h3F;
        tick(1);
        man_a = 1'b1;
        tick(1);
        chk("blank1 seg", 32'(seg_a), 32'h00);
        chk("blank1 sw", 32'(sw_a), 32'h1);
        chk("blank1 act", 32'(act_a), 32'h1);
        tick(1);
        chk("blank2 seg", 32'(seg_a), 32'h00);
        chk("blank2 sw", 32'(sw_a), 32'h1);
        tick(1);
        chk("new seg", 32'(seg_a), 32'h06);
        chk("new sw", 32'(sw_a), 32'h0);
        man_a = 1'b0;
        tick(3);
        chk("back seg", 32'(seg_a), 32'h3F);
        auto_a = 1'b1;
        tick(3);
        chk("dwell0 seg", 32'(seg_a), 32'h3F);
        tick(1);
        chk("auto blank seg", 32'(seg_a), 32'h00);
        chk("auto blank act", 32'(act_a), 32'h1);
        tick(2);
        chk("auto src1", 32'(seg_a), 32'h06);
        tick(3);
        chk("dwell1 seg", 32'(seg_a), 32'h06);
        tick(1);
        chk("auto blank2", 32'(seg_a), 32'h00);
        tick(2);
        chk("auto wrap", 32'(seg_a), 32'h3F);
        auto_a = 1'b0;
        man_a = 1'b1;
        tick(1);
        chk("retgt sw", 32'(sw_a), 32'h1);
        chk("retgt act1", 32'(act_a), 32'h1);
        man_a = 1'b0;
        tick(1);
        chk("retgt act0", 32'(act_a), 32'h0);
        tick(1);
        chk("retgt seg", 32'(seg_a), 32'h3F);
        chk("retgt end", 32'(sw_a), 32'h0);
        man_a = 1'b1;
        tick(2);
        chk("pre-reset sw", 32'(sw_a), 32'h1);
        reset = 1'b1;
        man_a = 1'b0;
        tick(1);
        chk("mid reset seg", 32'(seg_a), 32'h00);
        chk("mid reset act", 32'(act_a), 32'h0);
        chk("mid reset sw", 32'(sw_a), 32'h0);
        reset = 1'b0;
        tick(1);
        chk("post reset seg", 32'(seg_a), 32'h3F);
        auto_a = 1'b1;
        tick(2);
        auto_a = 1'b0;
        tick(3);
        chk("dwell clear seg", 32'(seg_a), 32'h3F);
        auto_a = 1'b1;
        tick(3);
        chk("dwell restart", 32'(seg_a), 32'h3F);
        tick(1);
        chk("dwell restart sw", 32'(sw_a), 32'h1);
        man_a = 1'b1;
        auto_a = 1'b0;
        tick(2);
        chk("auto off seg", 32'(seg_a), 32'h06);
        man_b = 2'd1;
        tick(1);
        chk("b direct seg", 32'(seg_b), 32'h06);
        chk("b direct act", 32'(act_b), 32'h1);
        chk("b direct sw", 32'(sw_b), 32'h0);
        man_b = 2'd3;
        tick(2);
        chk("b illegal act", 32'(act_b), 32'h1);
        chk("b illegal seg", 32'(seg_b), 32'h06);
        man_b = 2'd2;
        tick(1);
        chk("b src2", 32'(seg_b), 32'h5B);
        auto_b = 1'b1;
        tick(4);
        chk("b wrap seg", 32'(seg_b), 32'h3F);
        chk("b wrap act", 32'(act_b), 32'h0);
        tick(4);
        chk("b next seg", 32'(seg_b), 32'h06);
        chk("b next act", 32'(act_b), 32'h1);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
